// File: rtl/pipe_credit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_credit_pkg
// Shared width helpers for pipe_credit_fifo and its valid shadow.
//   clog2_floor1   : ceil(log2(n)), never less than 1 (a 0-bit vector is illegal)
//   ptr_width      : FIFO read/write pointer width for a given DEPTH
//   count_width    : FIFO occupancy width, must be able to hold DEPTH itself
//   inflight_width : in-flight counter width, must be able to hold LATENCY
// ---------------------------------------------------------------------------
package pipe_credit_pkg;

  function automatic int clog2_floor1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2_floor1(depth);
  endfunction

  function automatic int count_width(input int depth);
    return clog2_floor1(depth + 1);
  endfunction

  function automatic int inflight_width(input int latency);
    return clog2_floor1(latency + 1);
  endfunction

endpackage

// File: rtl/pipe_credit_fifo_shadow.sv
// ---------------------------------------------------------------------------
// pipe_valid_shadow
// Valid-bit shadow of a fixed-latency, non-stallable pipeline. A launch bit
// entering here comes out as 'arrive' exactly LATENCY cycles later, in the
// same cycle the matching data sits on the pipeline output.
// Ports:
//   clk    in  1  clock
//   reset  in  1  synchronous active-high reset, clears all shadow bits
//   launch in  1  an item enters the pipeline this cycle
//   arrive out 1  the item launched LATENCY cycles ago is on the output now
// ---------------------------------------------------------------------------
module pipe_valid_shadow #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  output logic arrive
);

  if (LATENCY == 0) begin : g_lat0
    // No pipeline stages: the item is on the output in its launch cycle.
    assign arrive = launch;
  end else if (LATENCY == 1) begin : g_lat1
    logic r_shadow;

    // Single-stage shadow of the launch bit.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_shadow <= 1'b0;
      end else begin
        r_shadow <= launch;
      end
    end

    assign arrive = r_shadow;
  end else begin : g_latn
    logic [LATENCY-1:0] r_shadow;

    // Multi-stage shadow: bit 0 takes the launch bit, the tail bit is arrive.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_shadow <= '0;
      end else begin
        r_shadow <= {r_shadow[LATENCY-2:0], launch};
      end
    end

    assign arrive = r_shadow[LATENCY-1];
  end

endmodule

// File: rtl/pipe_credit_fifo.sv
// ---------------------------------------------------------------------------
// pipe_credit_fifo
// Output-side companion to a fixed-latency pipeline that cannot stall. Items
// leaving the pipeline are captured into a DEPTH-entry FIFO, presented
// downstream as a valid/ready stream, and issue credit is granted upstream
// only while FIFO occupancy plus in-flight items is below DEPTH.
// Ports:
//   clk         in   1          clock
//   reset       in   1          synchronous active-high reset
//   issue_valid in   1          upstream offers an item to the pipeline
//   issue_ready out  1          credit available; launch = valid & ready
//   pipe_data   in   BIT_WIDTH  pipeline output data
//   out_valid   out  1          FIFO head valid
//   out_ready   in   1          downstream accepts the head
//   out_data    out  BIT_WIDTH  FIFO head data
//   count       out  CW         FIFO occupancy
//   inflight    out  IW         launched items not yet captured
//   overflow    out  1          sticky: capture attempted while full
// ---------------------------------------------------------------------------
module pipe_credit_fifo
  import pipe_credit_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int LATENCY   = 5,
  parameter int DEPTH     = 8,
  localparam int CW = count_width(DEPTH),
  localparam int IW = inflight_width(LATENCY)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [BIT_WIDTH-1:0] pipe_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [CW-1:0]        count,
  output logic [IW-1:0]        inflight,
  output logic                 overflow
);

  localparam int PW = ptr_width(DEPTH);

  logic                 w_launch;
  logic                 w_arrive;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_issue_ready_next;
  logic [PW-1:0]        w_wr_ptr_next;
  logic [PW-1:0]        w_rd_ptr_next;
  logic [CW-1:0]        w_count_next;
  logic [IW-1:0]        w_inflight_next;

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [IW-1:0]        r_inflight;
  logic                 r_issue_ready;
  logic                 r_out_valid;
  logic                 r_overflow;
  logic [BIT_WIDTH-1:0] r_mem [DEPTH];

  pipe_valid_shadow #(
    .LATENCY (LATENCY)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .launch (w_launch),
    .arrive (w_arrive)
  );

  assign w_launch = issue_valid & r_issue_ready;
  assign w_pop    = r_out_valid & out_ready;
  assign w_full   = (r_count == CW'(DEPTH));
  // A capture into a full FIFO is dropped; it only flags overflow.
  assign w_push   = w_arrive & ~w_full;

  // Next-state for pointers, occupancy, in-flight count and credit.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;

    if (w_push) begin
      if (r_wr_ptr == PW'(DEPTH - 1)) begin
        w_wr_ptr_next = '0;
      end else begin
        w_wr_ptr_next = r_wr_ptr + PW'(1);
      end
    end else begin
      w_wr_ptr_next = r_wr_ptr;
    end

    if (w_pop) begin
      if (r_rd_ptr == PW'(DEPTH - 1)) begin
        w_rd_ptr_next = '0;
      end else begin
        w_rd_ptr_next = r_rd_ptr + PW'(1);
      end
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end

    w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
    w_inflight_next = r_inflight + IW'(w_launch) - IW'(w_arrive);
    // Credit is registered from next-state, so a pop frees credit one cycle
    // later and issue_ready never depends combinationally on any input.
    w_issue_ready_next = ((32'(w_count_next) + 32'(w_inflight_next)) < 32'(DEPTH));
  end

  // State registers; reset wins over launch, arrive and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= '0;
      r_issue_ready <= 1'b1;
      r_out_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wr_ptr      <= w_wr_ptr_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_count       <= w_count_next;
      r_inflight    <= w_inflight_next;
      r_issue_ready <= w_issue_ready_next;
      r_out_valid   <= (w_count_next != '0);
      if (w_arrive & w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= pipe_data;
      end
    end
  end

  assign issue_ready = r_issue_ready;
  assign out_valid   = r_out_valid;
  // Read from registered storage only: an arriving item is not visible here
  // until the cycle after its capture.
  assign out_data    = r_mem[r_rd_ptr];
  assign count       = r_count;
  assign inflight    = r_inflight;
  assign overflow    = r_overflow;

endmodule
